unpad_row_stream: RTL and testbench
===================================

Name: unpad_row_stream

Overview:
- Inverse of the input padding stage. Consumes a frame of zero-padded feature-map rows and drops the top and bottom padding rows.
- Strips the left and right border pixel from every channel slice of each remaining row.
- Emits cropped rows with row index and last-row flag through a valid/ready handshake.
- Sits after the conv/pool pipeline, feeding rows back to output/DMA at native image size.

Parameters:
IMG_W, 416, cropped row width in pixels
IMG_H, 416, cropped rows per frame (padded frame carries IMG_H+2 rows)
PIX_W, 8, bits per pixel
CH, 3, channels packed per row (R,G,B); channel 0 in LSBs

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous: zero row counter, empty buffer, clear frame_err
in_valid  input  1  padded row valid
in_ready  output  1  row accepted when in_valid && in_ready
in_data  input  CH*(IMG_W+2)*PIX_W  padded row; per channel slice, border pixel at slice LSBs and MSBs
in_last  input  1  marks padded row IMG_H+1 (last row of padded frame)
out_valid  output  1  cropped row valid
out_ready  input  1  downstream accept
out_data  output  CH*IMG_W*PIX_W  cropped row, channel c at bits [c*IMG_W*PIX_W +: IMG_W*PIX_W]
out_row  output  clog2(IMG_H)  cropped row index 0..IMG_H-1
out_last  output  1  high with out_row==IMG_H-1
frame_err  output  1  sticky in_last/counter mismatch

Behaviour:
- Reset (reset low, async): row_idx=0, buffer empty, out_valid=0, out_data=0, out_row=0, out_last=0, frame_err=0, in_ready=0 while reset asserted. in_ready=1 from the first edge after release.
- Row counter row_idx runs 0..IMG_H+1 and increments on each accepted row. After IMG_H+1 it wraps to 0.
- Rows with row_idx 0 and IMG_H+1 are consumed and discarded, producing no output. Other rows are cropped and written to the buffer with out_row=row_idx-1.
- Crop: for each channel c, output slice = input slice bits [PIX_W +: IMG_W*PIX_W]. Border pixels are discarded.
- Output buffer: 2-entry FIFO; head drives out_* registers.
- in_ready = (fifo count < 2), registered-equivalent. Border rows also obey in_ready.
- Latency: an accepted data row is visible on out_valid the next cycle if the FIFO was empty.
- Throughput: 1 row/cycle when out_ready is held high.
- Simultaneous push and pop with count 2: in_ready is already low, so no push. Simultaneous push and pop with count 1: count stays 1, data order preserved.
- out_* stable while out_valid && !out_ready.
- in_last check on every accepted row:
  - in_last=1 with row_idx≠IMG_H+1 → frame_err set; row treated as border (discarded); row_idx forced to 0.
  - in_last=0 with row_idx==IMG_H+1 → frame_err set; row discarded; row_idx wraps to 0.
- clear: highest priority after reset. Same cycle as an accept, clear wins and the row is dropped. FIFO flushes, out_valid=0 next cycle.
- Reset mid-frame: all state lost. Next accepted row is treated as row_idx 0.

Optional Feature:
- Macro UNPAD_BORDER_CHECK_EN.
- Defined: every accepted row is checked for zero padding.
  - Border rows must be all-zero.
  - Data rows must have zero border pixels in every channel.
  - Any nonzero → sticky output border_err (1 bit, reset 0, cleared by clear), present only in this build. Data flow is unchanged.
- Undefined: no check logic, no border_err port.

Test Plan:
- IMG_W=4, IMG_H=3, CH=3, PIX_W=8: push 5 padded rows back-to-back, out_ready=1 → 3 outputs, out_row 0,1,2, out_last only on row 2; out_data = input minus border bytes.
- Data row channel slice 0x00_44_33_22_11_00 (MSB→LSB) → out slice 0x44332211 for each channel.
- Hold out_ready=0 while pushing → after 2 data rows in_ready=0. Release → rows drain in order and in_ready returns 1.
- in_last=1 on padded row 2 → frame_err=1, that row produces no output, next accepted row is border row 0.
- Assert reset low mid-frame with out_valid=1 → out_valid=0 immediately (async). After release, a 5-row frame is cropped correctly from row 0.
- With UNPAD_BORDER_CHECK_EN: border byte 0x01 in data row → border_err=1, out_data still correct. clear → border_err=0.

Source files
------------

// File: rtl/unpad_row_stream_if.sv
// Row-stream bus for unpad_row_stream: padded rows in, cropped rows (with index/last) out.
// The design side uses the slave modport; the producer/consumer side uses master.
interface unpad_row_stream_if #(
  parameter int unsigned IMG_W = 416,
  parameter int unsigned IMG_H = 416,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned CH    = 3
);
  localparam int unsigned IN_W  = CH * (IMG_W + 2) * PIX_W;
  localparam int unsigned OUT_W = CH * IMG_W * PIX_W;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [ROW_W-1:0] out_row;
  logic             out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_row, out_last
  );
endinterface

// File: rtl/unpad_row_stream.sv
// Drops the top/bottom padding rows of a frame and strips the left/right border pixel of every
// channel slice; cropped rows leave through a 2-entry FIFO. Optional zero-padding check: UNPAD_BORDER_CHECK_EN.
module unpad_row_stream #(
  parameter int unsigned IMG_W = 416,
  parameter int unsigned IMG_H = 416,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned CH    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  unpad_row_stream_if.slave bus,
  output logic frame_err
`ifdef UNPAD_BORDER_CHECK_EN
  ,
  output logic border_err
`endif
);
  localparam int unsigned SLICE_IN_W  = (IMG_W + 2) * PIX_W;
  localparam int unsigned SLICE_OUT_W = IMG_W * PIX_W;
  localparam int unsigned OUT_W       = CH * SLICE_OUT_W;
  localparam int unsigned ROW_W       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned CNT_W       = $clog2(IMG_H + 2);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(IMG_H + 1);
  localparam logic [CNT_W-1:0] FINAL_IDX = CNT_W'(IMG_H);

  logic [CNT_W-1:0] row_idx_q, row_idx_d;
  logic             frame_err_q, frame_err_d;
  logic             in_ready_q, in_ready_d;

  logic             head_valid_q, head_valid_d;
  logic [OUT_W-1:0] head_data_q, head_data_d;
  logic [ROW_W-1:0] head_row_q, head_row_d;
  logic             head_last_q, head_last_d;

  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic [ROW_W-1:0] skid_row_q, skid_row_d;
  logic             skid_last_q, skid_last_d;

  logic             accept, pop, push, last_pos, data_row;
  logic [OUT_W-1:0] crop_data;
  logic [ROW_W-1:0] crop_row;
  logic             crop_last;

  // Handshake decode and row classification of the row currently offered.
  always_comb begin
    accept    = bus.in_valid && in_ready_q;
    pop       = head_valid_q && bus.out_ready;
    last_pos  = (row_idx_q == LAST_IDX);
    data_row  = !bus.in_last && !last_pos && (row_idx_q != '0);
    push      = accept && data_row && !clear;
    crop_row  = ROW_W'(row_idx_q - CNT_W'(1));
    crop_last = (row_idx_q == FINAL_IDX);
  end

  // Keep the IMG_W interior pixels of each channel slice.
  always_comb begin
    crop_data = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      crop_data[c*SLICE_OUT_W +: SLICE_OUT_W] = bus.in_data[c*SLICE_IN_W + PIX_W +: SLICE_OUT_W];
    end
  end

  // Row counter and sticky framing error; an in_last mismatch resynchronises to row 0.
  always_comb begin
    row_idx_d   = row_idx_q;
    frame_err_d = frame_err_q;
    if (clear) begin
      row_idx_d   = '0;
      frame_err_d = 1'b0;
    end else if (accept) begin
      if (bus.in_last != last_pos) begin
        frame_err_d = 1'b1;
      end
      row_idx_d = (bus.in_last || last_pos) ? '0 : row_idx_q + CNT_W'(1);
    end
  end

  // Two-entry FIFO: head registers drive the outputs, skid entry absorbs one row of backpressure.
  always_comb begin
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    head_row_d   = head_row_q;
    head_last_d  = head_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_row_d   = skid_row_q;
    skid_last_d  = skid_last_q;
    if (clear) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!head_valid_q || pop) begin
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_data_d  = skid_data_q;
        head_row_d   = skid_row_q;
        head_last_d  = skid_last_q;
        skid_valid_d = push;
        if (push) begin
          skid_data_d = crop_data;
          skid_row_d  = crop_row;
          skid_last_d = crop_last;
        end
      end else begin
        head_valid_d = push;
        if (push) begin
          head_data_d = crop_data;
          head_row_d  = crop_row;
          head_last_d = crop_last;
        end
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = crop_data;
      skid_row_d   = crop_row;
      skid_last_d  = crop_last;
    end
    in_ready_d = !(head_valid_d && skid_valid_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_idx_q    <= '0;
      frame_err_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
      head_row_q   <= '0;
      head_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_row_q   <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      row_idx_q    <= row_idx_d;
      frame_err_q  <= frame_err_d;
      in_ready_q   <= in_ready_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
      head_row_q   <= head_row_d;
      head_last_q  <= head_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_row_q   <= skid_row_d;
      skid_last_q  <= skid_last_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = head_valid_q;
  assign bus.out_data  = head_data_q;
  assign bus.out_row   = head_row_q;
  assign bus.out_last  = head_last_q;
  assign frame_err     = frame_err_q;

`ifdef UNPAD_BORDER_CHECK_EN
  logic border_bad;
  logic border_err_q, border_err_d;

  // Border rows must be entirely zero; data rows only need zero edge pixels in each slice.
  always_comb begin
    border_bad = 1'b0;
    if (data_row) begin
      for (int unsigned c = 0; c < CH; c++) begin
        border_bad = border_bad
                   | (|bus.in_data[c*SLICE_IN_W +: PIX_W])
                   | (|bus.in_data[c*SLICE_IN_W + (IMG_W + 1) * PIX_W +: PIX_W]);
      end
    end else begin
      border_bad = |bus.in_data;
    end
    border_err_d = border_err_q;
    if (clear) begin
      border_err_d = 1'b0;
    end else if (accept && border_bad) begin
      border_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      border_err_q <= 1'b0;
    end else begin
      border_err_q <= border_err_d;
    end
  end

  assign border_err = border_err_q;
`endif
endmodule

// File: tb/tb_unpad_row_stream.sv
// Randomised bench for unpad_row_stream with a queue-based frame model plus directed literal checks.
`timescale 1ns/1ps
module tb_unpad_row_stream;
  localparam int unsigned W     = 4;
  localparam int unsigned H     = 3;
  localparam int unsigned P     = 8;
  localparam int unsigned C     = 3;
  localparam int unsigned IN_W  = C * (W + 2) * P;
  localparam int unsigned OUT_W = C * W * P;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic frame_err;
`ifdef UNPAD_BORDER_CHECK_EN
  logic border_err;
`endif

  unpad_row_stream_if #(.IMG_W(W), .IMG_H(H), .PIX_W(P), .CH(C)) bus ();

  unpad_row_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(P), .CH(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .bus       (bus),
    .frame_err (frame_err)
`ifdef UNPAD_BORDER_CHECK_EN
    ,
    .border_err(border_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] d;
    int               row;
    logic             last;
  } exp_t;

  exp_t             q[$];
  int               pos;
  logic             m_ferr;
  logic             m_berr;
  int               n_checks;
  int               n_fail;
  logic [OUT_W-1:0] log_d[$];
  int               log_row[$];
  logic             log_last[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] crop(input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int c = 0; c < int'(C); c++)
      for (int x = 0; x < int'(W); x++)
        r[(c*W + x)*P +: P] = d[(c*(W+2) + x + 1)*P +: P];
    return r;
  endfunction

  function automatic logic bad_border(input logic [IN_W-1:0] d, input logic data_row);
    if (!data_row) return (d != '0);
    for (int c = 0; c < int'(C); c++) begin
      if (d[(c*(W+2))*P +: P] != '0 || d[(c*(W+2) + W + 1)*P +: P] != '0) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [IN_W-1:0] make_row(input int p, input bit noisy);
    logic [IN_W-1:0] r;
    for (int i = 0; i < int'(IN_W / P); i++) r[i*P +: P] = P'($urandom);
    if (!noisy) begin
      if (p == 0 || p >= int'(H) + 1) begin
        r = '0;
      end else begin
        for (int c = 0; c < int'(C); c++) begin
          r[(c*(W+2))*P +: P]         = '0;
          r[(c*(W+2) + W + 1)*P +: P] = '0;
        end
      end
    end
    return r;
  endfunction

  task automatic model_step(input logic acc, input logic pop, input logic clr,
                            input logic [IN_W-1:0] d, input logic l);
    bit   lastpos;
    bit   data;
    exp_t e;
    if (clr) begin
      q.delete();
      pos    = 0;
      m_ferr = 1'b0;
      m_berr = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        lastpos = (pos == int'(H) + 1);
        data    = !l && pos >= 1 && pos <= int'(H);
        if (l != lastpos) m_ferr = 1'b1;
        if (bad_border(d, data)) m_berr = 1'b1;
        if (data) begin
          e.d    = crop(d);
          e.row  = pos - 1;
          e.last = (pos == int'(H));
          q.push_back(e);
        end
        pos = (l || lastpos) ? 0 : pos + 1;
      end
    end
  endtask

  task automatic compare();
    check("in_ready", 128'(bus.in_ready), 128'(q.size() < 2));
    check("out_valid", 128'(bus.out_valid), 128'(q.size() > 0));
    if (q.size() > 0) begin
      check("out_data", 128'(bus.out_data), 128'(q[0].d));
      check("out_row", 128'(bus.out_row), 128'(q[0].row));
      check("out_last", 128'(bus.out_last), 128'(q[0].last));
    end
    check("frame_err", 128'(frame_err), 128'(m_ferr));
`ifdef UNPAD_BORDER_CHECK_EN
    check("border_err", 128'(border_err), 128'(m_berr));
`endif
  endtask

  // One cycle: check outputs at the negedge, drive new inputs, advance the model to the next edge.
  task automatic cyc(input logic v, input logic [IN_W-1:0] d, input logic l,
                     input logic rdy, input logic clr);
    logic acc;
    logic pop;
    @(negedge clk);
    compare();
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = rdy;
    clear         = clr;
    acc = v && (q.size() < 2);
    pop = rdy && (q.size() > 0);
    if (pop && !clr) begin
      log_d.push_back(bus.out_data);
      log_row.push_back(int'(bus.out_row));
      log_last.push_back(bus.out_last);
    end
    model_step(acc, pop, clr, d, l);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic frame();
    for (int p = 0; p <= int'(H) + 1; p++) cyc(1'b1, make_row(p, 1'b0), p == int'(H) + 1, 1'b1, 1'b0);
  endtask

  task automatic clear_log();
    log_d.delete();
    log_row.delete();
    log_last.delete();
  endtask

  task automatic rst_checks();
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(0));
    check("rst_out_data", 128'(bus.out_data), 128'(0));
    check("rst_out_row", 128'(bus.out_row), 128'(0));
    check("rst_out_last", 128'(bus.out_last), 128'(0));
    check("rst_frame_err", 128'(frame_err), 128'(0));
`ifdef UNPAD_BORDER_CHECK_EN
    check("rst_border_err", 128'(border_err), 128'(0));
`endif
  endtask

  task automatic do_reset(input bit expect_valid);
    @(negedge clk);
    if (expect_valid) check("pre_rst_out_valid", 128'(bus.out_valid), 128'(1));
    reset = 1'b0;
    #1;
    rst_checks();
    q.delete();
    pos    = 0;
    m_ferr = 1'b0;
    m_berr = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    clear         = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0] r1;
    logic            l;
    n_checks = 0;
    n_fail   = 0;
    pos      = 0;
    m_ferr   = 1'b0;
    m_berr   = 1'b0;
    reset         = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #2 reset = 1'b0;
    #1 rst_checks();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);

    // Back-to-back frame, known pixel pattern on the first data row.
    clear_log();
    r1 = {3{48'h004433221100}};
    cyc(1'b1, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, r1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, make_row(2, 1'b0), 1'b0, 1'b1, 1'b0);
    cyc(1'b1, make_row(3, 1'b0), 1'b0, 1'b1, 1'b0);
    cyc(1'b1, '0, 1'b1, 1'b1, 1'b0);
    idle(3);
    check("f1_count", 128'(log_row.size()), 128'(3));
    if (log_row.size() == 3) begin
      check("f1_row0", 128'(log_row[0]), 128'(0));
      check("f1_row1", 128'(log_row[1]), 128'(1));
      check("f1_row2", 128'(log_row[2]), 128'(2));
      check("f1_last0", 128'(log_last[0]), 128'(0));
      check("f1_last1", 128'(log_last[1]), 128'(0));
      check("f1_last2", 128'(log_last[2]), 128'(1));
      check("f1_data0", 128'(log_d[0]), 128'(96'h44332211_44332211_44332211));
    end

    // Backpressure: two data rows fill the FIFO.
    clear_log();
    cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, make_row(1, 1'b0), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, make_row(2, 1'b0), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("hold_in_ready", 128'(bus.in_ready), 128'(0));
    check("hold_out_row", 128'(bus.out_row), 128'(0));
    idle(3);
    check("drain_in_ready", 128'(bus.in_ready), 128'(1));
    cyc(1'b1, make_row(3, 1'b0), 1'b0, 1'b1, 1'b0);
    cyc(1'b1, '0, 1'b1, 1'b1, 1'b0);
    idle(2);
    check("bp_count", 128'(log_row.size()), 128'(3));
    if (log_row.size() == 3) check("bp_order", 128'({log_row[0], log_row[1], log_row[2]}), 128'({32'd0, 32'd1, 32'd2}));

    // Early in_last on padded row 2.
    clear_log();
    cyc(1'b1, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, make_row(1, 1'b0), 1'b0, 1'b1, 1'b0);
    cyc(1'b1, make_row(2, 1'b0), 1'b1, 1'b1, 1'b0);
    idle(1);
    check("err_frame_err", 128'(frame_err), 128'(1));
    check("err_count", 128'(log_row.size()), 128'(1));
    frame();
    idle(2);
    check("resync_count", 128'(log_row.size()), 128'(4));
    if (log_row.size() == 4) begin
      check("resync_row0", 128'(log_row[1]), 128'(0));
      check("resync_row2", 128'(log_row[3]), 128'(2));
    end
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle(1);
    check("clear_frame_err", 128'(frame_err), 128'(0));

    // Reset mid-frame with a row waiting at the output.
    cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, make_row(1, 1'b0), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    do_reset(1'b1);
    clear_log();
    frame();
    idle(2);
    check("post_rst_count", 128'(log_row.size()), 128'(3));
    if (log_row.size() == 3) check("post_rst_row0", 128'(log_row[0]), 128'(0));

`ifdef UNPAD_BORDER_CHECK_EN
    r1 = make_row(1, 1'b0);
    r1[7:0] = 8'h01;
    cyc(1'b1, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, r1, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("border_err_set", 128'(border_err), 128'(1));
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    idle(1);
    check("border_err_clear", 128'(border_err), 128'(0));
`endif

    // Random traffic, framing errors, clears and one asynchronous reset.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset(1'b0);
      l = (pos == int'(H) + 1) ^ ($urandom % 25 == 0);
      cyc($urandom % 4 != 0, make_row(pos, $urandom % 20 == 0), l, $urandom % 4 != 0, $urandom % 150 == 0);
    end
    for (int k = 0; k < 10 && q.size() > 0; k++) idle(1);
    idle(1);
    check("final_out_valid", 128'(bus.out_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
